mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register plus write-back select for the 5-stage MIPS core.
//   - Captures MEM-stage results: load data, ALU result, link PC, rd, control.
//   - Drives the register-file write port.
//   - Holds on stall, bubbles on flush, freezes the pipe once a HALT retires.
//   - Sits directly downstream of MEM, which produces i_dataread in the same cycle as its address.
// PARAMETERS
//   DATA_WIDTH      32  datapath width
//   REG_ADDR_WIDTH  5   register index width
//   CNT_WIDTH       32  retire counter width (RETIRE_CNT_EN only)
// PORTS
//   i_clock      in   1               clock, all flops on rising edge
//   i_reset_n    in   1               asynchronous active-low reset
//   i_stall      in   1               hold latch contents this cycle
//   i_flush      in   1               load a bubble this cycle
//   i_valid      in   1               MEM stage holds a real instruction
//   i_halt       in   1               instruction in MEM is HALT
//   i_regwrite   in   1               instruction writes rd
//   i_wbsel      in   2               write-back source select (see package)
//   i_aluresult  in   DATA_WIDTH      ALU result / effective address
//   i_dataread   in   DATA_WIDTH      load data from MEM (already sized and sign-extended)
//   i_pclink     in   DATA_WIDTH      return address for JAL/JALR (PC+8)
//   i_rd         in   REG_ADDR_WIDTH  destination register
//   o_regwrite   out  1               register-file write enable
//   o_rd         out  REG_ADDR_WIDTH  register-file write address
//   o_writedata  out  DATA_WIDTH      register-file write data
//   o_halted     out  1               pipeline halted, debug unit may read state
//   o_retired    out  CNT_WIDTH       retired-instruction count
// BEHAVIOUR
//   - Reset (async, i_reset_n=0):
//     - all latch fields 0; valid_q=0; state=RUN.
//     - o_regwrite=0, o_rd=0, o_writedata=0, o_halted=0, o_retired=0.
//   - Per rising edge in state RUN:
//     - i_flush=1: valid_q<=0, halt_q<=0; other fields don't-care. Flush beats stall.
//     - else i_stall=1: all fields hold.
//     - else: capture every input; valid_q<=i_valid.
//   - Latency: one cycle, MEM inputs to WB outputs.
//   - Outputs, combinational from the latch:
//     - o_regwrite = valid_q & regwrite_q & (rd_q!=0). $zero is never written.
//     - o_rd = rd_q.
//     - o_writedata by wbsel_q: WB_ALU->alu_q, WB_MEM->data_q, WB_LINK->pclink_q,
//       reserved 2'b11->alu_q.
//   - FSM (states RUN, HALT_SEEN, HALTED):
//     - RUN->HALT_SEEN when valid_q & halt_q. HALT itself never writes: o_regwrite=0.
//     - HALT_SEEN->HALTED unconditionally on the next edge.
//     - In HALT_SEEN and HALTED the latch ignores all inputs and valid_q is forced to 0.
//     - o_halted=1 only in HALTED.
//     - Only reset leaves HALTED; stall and flush have no effect there.
//   - Reset mid-operation discards the latched instruction; no partial write occurs.
// CONFIGURATION
//   RETIRE_CNT_EN defined:
//     - o_retired increments on each edge where valid_q=1, halt_q=0 and state=RUN.
//     - Bubbles and HALT are not counted; o_retired saturates at all-ones.
//   RETIRE_CNT_EN undefined:
//     - port kept; o_retired tied to 0; no counter flops.
// STRUCTURE
//   - mips_pkg holds WB_ALU=2'b00, WB_MEM=2'b01, WB_LINK=2'b10 and the state
//     encodings RUN=2'd0, HALT_SEEN=2'd1, HALTED=2'd2.
//   - Sub-module wb_mux: the combinational write-back select, reused by the forwarding unit.
// TESTING
//   1. Reset: i_reset_n low mid-run with valid data latched -> all outputs 0 in the
//      same cycle, state RUN.
//   2. Load: i_valid=1, regwrite=1, wbsel=WB_MEM, dataread=0xFFFF_FF80, rd=8
//      -> next cycle o_regwrite=1, o_rd=8, o_writedata=0xFFFF_FF80.
//   3. $zero: rd=0, regwrite=1, wbsel=WB_ALU, alu=0x1234 -> o_regwrite=0.
//   4. Stall then flush: latch JAL (wbsel=WB_LINK, pclink=0x0000_0048, rd=31), then
//      stall 3 cycles -> outputs unchanged; then assert i_flush and i_stall together
//      -> o_regwrite=0 next cycle.
//   5. Halt: HALT enters with valid=1 -> HALT_SEEN one cycle later, o_halted=1 two
//      cycles later; further writes with i_valid=1 -> o_regwrite stays 0 until reset.
//   6. RETIRE_CNT_EN: 5 valid, 2 bubble, 1 HALT -> o_retired=5. With CNT_WIDTH=2 and
//      5 valid -> o_retired saturates at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared write-back select codes and MEM/WB pipe state encodings
package mips_pkg;
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_SEEN = 2'd1,
        HALTED    = 2'd2
    } state_t;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: combinational write-back source select, shared with the forwarding unit
module wb_mux
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_wbsel,
    input  logic [DATA_WIDTH-1:0] i_alu,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_pclink,
    output logic [DATA_WIDTH-1:0] o_data
);
    // reserved code 2'b11 falls back to the ALU result, same as WB_ALU
    always_comb begin
        o_data = (i_wbsel == WB_MEM) ? i_data : (i_wbsel == WB_LINK) ? i_pclink : i_alu;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back select and halt freeze.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic                      i_halt,
    input  logic                      i_regwrite,
    input  logic [1:0]                i_wbsel,
    input  logic [DATA_WIDTH-1:0]     i_aluresult,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_pclink,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    output logic                      o_regwrite,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [DATA_WIDTH-1:0]     o_writedata,
    output logic                      o_halted,
    output logic [CNT_WIDTH-1:0]      o_retired
);
    state_t                    r_state;
    state_t                    w_next;
    logic                      r_valid;
    logic                      r_halt;
    logic                      r_regwrite;
    logic [1:0]                r_wbsel;
    logic [DATA_WIDTH-1:0]     r_alu;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DATA_WIDTH-1:0]     r_pclink;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      w_run;
    logic                      w_valid;

    assign w_run   = (r_state == RUN);
    // once a HALT has retired the latched slot is dead, even if it was captured on the retiring edge
    assign w_valid = r_valid & w_run;

    // next state: a retiring HALT freezes the pipe after one drain cycle
    always_comb begin
        w_next = (r_state == RUN) ? ((r_valid && r_halt) ? HALT_SEEN : RUN) : HALTED;
    end

    // state register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= RUN;
        else            r_state <= w_next;
    end

    // pipeline latch: flush beats stall, frozen after HALT
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid    <= 1'b0;
            r_halt     <= 1'b0;
            r_regwrite <= 1'b0;
            r_wbsel    <= WB_ALU;
            r_alu      <= '0;
            r_data     <= '0;
            r_pclink   <= '0;
            r_rd       <= '0;
        end else if (!w_run) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
        end else if (!i_stall) begin
            r_valid    <= i_valid;
            r_halt     <= i_halt;
            r_regwrite <= i_regwrite;
            r_wbsel    <= i_wbsel;
            r_alu      <= i_aluresult;
            r_data     <= i_dataread;
            r_pclink   <= i_pclink;
            r_rd       <= i_rd;
        end
    end

    assign o_regwrite = w_valid & ~r_halt & r_regwrite & (r_rd != '0);
    assign o_rd       = r_rd;
    assign o_halted   = (r_state == HALTED);

    wb_mux #(.DATA_WIDTH(DATA_WIDTH)) u_wb_mux (
        .i_wbsel  (r_wbsel),
        .i_alu    (r_alu),
        .i_data   (r_data),
        .i_pclink (r_pclink),
        .o_data   (o_writedata)
    );

`ifdef RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] r_retired;

    // count non-HALT instructions leaving the latch while running, saturating at all-ones
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)                            r_retired <= '0;
        else if (w_valid && !r_halt && !(&r_retired)) r_retired <= r_retired + CNT_WIDTH'(1);
    end

    assign o_retired = r_retired;
`else
    assign o_retired = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized self-checking bench with a behavioural MEM/WB model
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, valid = 1'b0, halt = 1'b0, regwrite = 1'b0;
    logic [1:0]  wbsel = 2'b00;
    logic [31:0] alu = '0, dread = '0, pclink = '0;
    logic [4:0]  rd = '0;
    logic        we, halted, we2, halted2;
    logic [4:0]  wrd, wrd2;
    logic [31:0] wdata, wdata2, retired;
    logic [1:0]  retired2;

    int checks = 0;
    int errors = 0;

`ifdef RETIRE_CNT_EN
    localparam longint EXP_RET = 5, EXP_RET2 = 3;
    localparam bit     CNT_ON  = 1'b1;
`else
    localparam longint EXP_RET = 0, EXP_RET2 = 0;
    localparam bit     CNT_ON  = 1'b0;
`endif

    mem_wb_stage dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_halt(halt), .i_regwrite(regwrite), .i_wbsel(wbsel),
        .i_aluresult(alu), .i_dataread(dread), .i_pclink(pclink), .i_rd(rd),
        .o_regwrite(we), .o_rd(wrd), .o_writedata(wdata), .o_halted(halted),
        .o_retired(retired)
    );

    mem_wb_stage #(.CNT_WIDTH(2)) dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_halt(halt), .i_regwrite(regwrite), .i_wbsel(wbsel),
        .i_aluresult(alu), .i_dataread(dread), .i_pclink(pclink), .i_rd(rd),
        .o_regwrite(we2), .o_rd(wrd2), .o_writedata(wdata2), .o_halted(halted2),
        .o_retired(retired2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: the instruction sitting in WB, the pipe phase and the retire tally
    typedef struct {
        logic        v, h, rw;
        logic [1:0]  sel;
        logic [31:0] alu, data, link;
        logic [4:0]  rd;
    } ins_t;

    ins_t   m = '{v: 0, h: 0, rw: 0, sel: 0, alu: 0, data: 0, link: 0, rd: 0};
    int     m_phase = 0;
    longint m_cnt = 0;
    bit     halt_retiring;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '{v: 0, h: 0, rw: 0, sel: 0, alu: 0, data: 0, link: 0, rd: 0};
            m_phase = 0;
            m_cnt = 0;
        end else if (m_phase == 0) begin
            if (m.v && !m.h) m_cnt++;
            halt_retiring = m.v && m.h;
            if (flush) begin
                m.v = 0;
                m.h = 0;
            end else if (!stall) begin
                m = '{v: valid, h: halt, rw: regwrite, sel: wbsel, alu: alu, data: dread, link: pclink, rd: rd};
            end
            if (halt_retiring) m_phase = 1;
        end else begin
            m.v = 0;
            m_phase = 2;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("regwrite", we, (m_phase == 0 && m.v && !m.h && m.rw && m.rd != 0));
            chk("rd", wrd, m.rd);
            chk("writedata", wdata, m.sel == 2'b01 ? m.data : m.sel == 2'b10 ? m.link : m.alu);
            chk("halted", halted, m_phase == 2);
            chk("retired", retired, CNT_ON ? m_cnt : 0);
            chk("retired_sat", retired2, CNT_ON ? (m_cnt > 3 ? 3 : m_cnt) : 0);
        end
    end

    task automatic drive(input logic v, h, rw, input logic [1:0] sel,
                         input logic [31:0] a, d, l, input logic [4:0] r);
        valid = v; halt = h; regwrite = rw; wbsel = sel;
        alu = a; dread = d; pclink = l; rd = r;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_we"}, we, 0);
        chk({name, "_rd"}, wrd, 0);
        chk({name, "_wdata"}, wdata, 0);
        chk({name, "_halted"}, halted, 0);
        chk({name, "_retired"}, retired, 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(0, 0, 0, WB_ALU, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, WB_ALU, 0, 0, 0, 0);
        repeat (2) step();
        chk_zero("por");
        rst_n = 1'b1;
        drive(1, 0, 1, WB_MEM, 32'h55, 32'hFFFF_FF80, 0, 5'd8);
        step();
        chk("load_we", we, 1);
        chk("load_rd", wrd, 8);
        chk("load_wdata", wdata, 32'hFFFF_FF80);
        drive(1, 0, 1, WB_ALU, 32'h1234, 32'h9, 0, 5'd0);
        step();
        chk("zero_we", we, 0);
        chk("zero_wdata", wdata, 32'h1234);
        drive(1, 0, 1, WB_LINK, 32'hAB, 32'hCD, 32'h0000_0048, 5'd31);
        step();
        drive(1, 0, 1, WB_MEM, 32'h1, 32'h2, 32'h3, 5'd4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_we", we, 1);
            chk("stall_rd", wrd, 31);
            chk("stall_wdata", wdata, 32'h48);
        end
        flush = 1'b1;
        step();
        chk("flush_we", we, 0);
        drive(1, 0, 1, WB_MEM, 0, 32'hDEAD_BEEF, 0, 5'd8);
        step();
        chk("pre_rst_we", we, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        drive(0, 0, 0, WB_ALU, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 2'($urandom), $urandom, $urandom, $urandom, 5'(1 + $urandom_range(0, 30)));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, WB_ALU, $urandom, $urandom, $urandom, 5'd3);
            step();
        end
        drive(1, 1, 1, WB_ALU, 32'h77, 0, 0, 5'd5);
        step();
        chk("halt_in_wb_we", we, 0);
        chk("halt_in_wb_halted", halted, 0);
        drive(1, 0, 1, WB_ALU, 32'h99, 0, 0, 5'd9);
        step();
        chk("halt_seen_we", we, 0);
        chk("halt_seen_halted", halted, 0);
        step();
        chk("halted", halted, 1);
        chk("retired_total", retired, EXP_RET);
        chk("retired_saturated", retired2, EXP_RET2);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, WB_ALU, $urandom, 0, 0, 5'd10);
            stall = 1'($urandom);
            flush = 1'($urandom);
            step();
            chk("frozen_we", we, 0);
            chk("frozen_halted", halted, 1);
        end
        do_reset();
        chk("unfrozen", halted, 0);
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 150; i++) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, 1'($urandom), 2'($urandom),
                      $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
                stall = ($urandom_range(0, 4) == 0);
                flush = ($urandom_range(0, 7) == 0);
                step();
            end
            do_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
